// File: rtl/sdiv_pkg.sv
// Shared types and helpers for the pipelined restoring divider.
package sdiv_pkg;

    localparam int TAG_W_MAX = 16;
    localparam int NEG_W     = 64;

    // Per-stage control bundle; the tag is carried at TAG_W_MAX and trimmed at the output.
    typedef struct packed {
        logic                 vld;
        logic                 q_neg;
        logic                 r_neg;
        logic                 dz;
        logic                 ovf;
        logic [TAG_W_MAX-1:0] tag;
    } sdiv_flags_t;

    function automatic int sdiv_depth(input int m, input int spr);
        return m / spr;
    endfunction

    // Two's-complement negation; callers keep the low M or N bits, which wraps correctly.
    function automatic logic [NEG_W-1:0] cneg(input logic neg, input logic [NEG_W-1:0] v);
        return neg ? (~v + NEG_W'(1)) : v;
    endfunction

endpackage

// File: rtl/sdiv_stage.sv
// SPR restoring division steps, purely combinational.
// Latency: 0 cycles. Backpressure: none, the caller registers around it.
// Ready: n/a (no handshake).
module sdiv_stage #(
    parameter int N   = 32,
    parameter int SPR = 1
) (
    input  logic [N-1:0]   rem,
    input  logic [N-1:0]   dmag,
    input  logic [SPR-1:0] nbits,
    output logic [N-1:0]   rem_nxt,
    output logic [SPR-1:0] qbits
);

    always_comb begin
        logic [N-1:0] r;
        logic [N:0]   t;
        logic [N+1:0] diff;
        r     = rem;
        t     = '0;
        diff  = '0;
        qbits = '0;
        for (int i = SPR - 1; i >= 0; i--) begin
            t        = {r, nbits[i]};
            diff     = {1'b0, t} - {2'b00, dmag};
            qbits[i] = ~diff[N+1];
            r        = diff[N+1] ? t[N-1:0] : diff[N-1:0];
        end
        rem_nxt = r;
    end

endmodule

// File: rtl/sdiv_pipe.sv
// Pipelined signed/unsigned restoring divider with tag and valid/ready handshake.
// Latency: M/SPR + 2 registers (input, compute stages, output); 1 op/cycle.
// Backpressure: whole pipe stalls as one shift register when out_vld & ~out_rdy; in_rdy follows. SDIV_DZ_FLAG_EN adds out_dz.
module sdiv_pipe
    import sdiv_pkg::*;
#(
    parameter int M     = 32,
    parameter int N     = 32,
    parameter int SPR   = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic             in_sgn,
    input  logic [M-1:0]     in_n,
    input  logic [N-1:0]     in_d,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [M-1:0]     out_q,
    output logic [N-1:0]     out_r,
    output logic [TAG_W-1:0] out_tag
`ifdef SDIV_DZ_FLAG_EN
    ,
    output logic             out_dz
`endif
);

    localparam int L = sdiv_depth(M, SPR);

    if (M < N) begin : g_chk_mn
        $error("sdiv_pipe: M must be >= N");
    end
    if (SPR < 1 || (M % SPR) != 0) begin : g_chk_spr
        $error("sdiv_pipe: SPR must divide M");
    end
    if (TAG_W > TAG_W_MAX || M >= NEG_W) begin : g_chk_w
        $error("sdiv_pipe: TAG_W or M too wide");
    end

    logic adv;
    assign adv    = ~out_vld | out_rdy;
    assign in_rdy = adv;

    sdiv_flags_t    fl_r  [0:L];
    logic [N-1:0]   rem_r [0:L];
    logic [M-1:0]   nq_r  [0:L];
    logic [N-1:0]   d_r   [0:L];
    logic [N-1:0]   rem_c [1:L];
    logic [M-1:0]   nq_c  [1:L];

    // nq_r holds the unconsumed numerator bits on top and collected quotient bits below.
    for (genvar k = 1; k <= L; k++) begin : g_stage
        logic [SPR-1:0]   qb;
        logic [M+SPR-1:0] cat;
        sdiv_stage #(.N(N), .SPR(SPR)) u_stage (
            .rem     (rem_r[k-1]),
            .dmag    (d_r[k-1]),
            .nbits   (nq_r[k-1][M-1 -: SPR]),
            .rem_nxt (rem_c[k]),
            .qbits   (qb)
        );
        assign cat     = {nq_r[k-1], qb};
        assign nq_c[k] = cat[M-1:0];
    end

    logic [NEG_W-1:0] n_abs_w, d_abs_w;
    sdiv_flags_t      fl_in;

    assign n_abs_w = cneg(in_sgn & in_n[M-1], NEG_W'(in_n));
    assign d_abs_w = cneg(in_sgn & in_d[N-1], NEG_W'(in_d));

    always_comb begin
        fl_in       = '0;
        fl_in.vld   = in_vld;
        fl_in.q_neg = in_sgn & (in_n[M-1] ^ in_d[N-1]);
        fl_in.r_neg = in_sgn & in_n[M-1];
        fl_in.dz    = (in_d == '0);
        fl_in.ovf   = in_sgn & (in_n == {1'b1, {(M-1){1'b0}}}) & (in_d == '1);
        fl_in.tag   = TAG_W_MAX'(in_tag);
    end

    logic [NEG_W-1:0] qn_w, rn_w;
    logic [M-1:0]     q_fin;
    logic [N-1:0]     r_fin;

    assign qn_w = cneg(fl_r[L].q_neg, NEG_W'(nq_r[L]));
    assign rn_w = cneg(fl_r[L].r_neg, NEG_W'(rem_r[L]));

    // With d=0 no step ever borrows, so rem ends as |n| mod 2^N and the sign fix
    // restores in_n[N-1:0]; only the quotient needs an explicit override.
    always_comb begin
        q_fin = qn_w[M-1:0];
        r_fin = rn_w[N-1:0];
        if (fl_r[L].dz) begin
            q_fin = '1;
        end else if (fl_r[L].ovf) begin
            q_fin = {1'b1, {(M-1){1'b0}}};
            r_fin = '0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{n_abs_w, d_abs_w, qn_w, rn_w, fl_r[L].tag, d_r[L]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= L; k++) begin
                fl_r[k]  <= '0;
                rem_r[k] <= '0;
                nq_r[k]  <= '0;
                d_r[k]   <= '0;
            end
            out_vld <= 1'b0;
            out_q   <= '0;
            out_r   <= '0;
            out_tag <= '0;
`ifdef SDIV_DZ_FLAG_EN
            out_dz  <= 1'b0;
`endif
        end else if (adv) begin
            fl_r[0]  <= fl_in;
            rem_r[0] <= '0;
            nq_r[0]  <= n_abs_w[M-1:0];
            d_r[0]   <= d_abs_w[N-1:0];
            for (int k = 1; k <= L; k++) begin
                fl_r[k]  <= fl_r[k-1];
                rem_r[k] <= rem_c[k];
                nq_r[k]  <= nq_c[k];
                d_r[k]   <= d_r[k-1];
            end
            out_vld <= fl_r[L].vld;
            out_q   <= q_fin;
            out_r   <= r_fin;
            out_tag <= fl_r[L].tag[TAG_W-1:0];
`ifdef SDIV_DZ_FLAG_EN
            out_dz  <= fl_r[L].dz;
`endif
        end
    end

endmodule

// File: tb/tb_sdiv_pipe.sv
// Directed bench for sdiv_pipe at M=N=8: one instance with SPR=1 (L=8), one with SPR=4 (L=2).
module tb_sdiv_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_vld [2];
    logic       in_rdy [2];
    logic       in_sgn [2];
    logic [7:0] in_n   [2];
    logic [7:0] in_d   [2];
    logic [3:0] in_tag [2];
    logic       out_vld[2];
    logic       out_rdy[2];
    logic [7:0] out_q  [2];
    logic [7:0] out_r  [2];
    logic [3:0] out_tag[2];
`ifdef SDIV_DZ_FLAG_EN
    logic       out_dz [2];
`endif

    sdiv_pipe #(.M(8), .N(8), .SPR(1), .TAG_W(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_vld(in_vld[0]), .in_rdy(in_rdy[0]), .in_sgn(in_sgn[0]),
        .in_n(in_n[0]), .in_d(in_d[0]), .in_tag(in_tag[0]),
        .out_vld(out_vld[0]), .out_rdy(out_rdy[0]), .out_q(out_q[0]),
        .out_r(out_r[0]), .out_tag(out_tag[0])
`ifdef SDIV_DZ_FLAG_EN
        , .out_dz(out_dz[0])
`endif
    );

    sdiv_pipe #(.M(8), .N(8), .SPR(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_vld(in_vld[1]), .in_rdy(in_rdy[1]), .in_sgn(in_sgn[1]),
        .in_n(in_n[1]), .in_d(in_d[1]), .in_tag(in_tag[1]),
        .out_vld(out_vld[1]), .out_rdy(out_rdy[1]), .out_q(out_q[1]),
        .out_r(out_r[1]), .out_tag(out_tag[1])
`ifdef SDIV_DZ_FLAG_EN
        , .out_dz(out_dz[1])
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    bit         sg_a[20];
    logic [7:0] n_a [20];
    logic [7:0] d_a [20];

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
    endtask

    // Independent reference: SV integer division truncates toward zero, % follows the dividend.
    function automatic logic [15:0] model(input bit sgn, input logic [7:0] n, input logic [7:0] d);
        int sn, sd, q, r;
        if (d == 8'h00) return {8'hFF, n};
        if (sgn) begin
            if (n == 8'h80 && d == 8'hFF) return {8'h80, 8'h00};
            sn = int'($signed(n));
            sd = int'($signed(d));
        end else begin
            sn = int'(n);
            sd = int'(d);
        end
        q = sn / sd;
        r = sn % sd;
        return {q[7:0], r[7:0]};
    endfunction

    // Entered and left at a falling edge with the selected pipe empty.
    task automatic single(input int d, input string nm, input bit sgn, input logic [7:0] n,
                          input logic [7:0] den, input logic [3:0] tag, input logic [7:0] eq,
                          input logic [7:0] er, input bit edz, input int elat);
        int lat;
        out_rdy[d] = 1'b1;
        in_sgn[d]  = sgn;
        in_n[d]    = n;
        in_d[d]    = den;
        in_tag[d]  = tag;
        in_vld[d]  = 1'b1;
        @(negedge clk);
        in_vld[d] = 1'b0;
        lat = 0;
        while (!out_vld[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(elat));
        chk({nm, "_q"}, 32'(out_q[d]), 32'(eq));
        chk({nm, "_r"}, 32'(out_r[d]), 32'(er));
        chk({nm, "_tag"}, 32'(out_tag[d]), 32'(tag));
`ifdef SDIV_DZ_FLAG_EN
        chk({nm, "_dz"}, 32'(out_dz[d]), 32'(edz));
`else
        if (edz) lat = 0;
`endif
        @(negedge clk);
    endtask

    task automatic stream(input int d);
        int tx, rx, cyc;
        bit stall, prev_stall;
        logic [7:0] hq, hr;
        logic [3:0] ht;
        logic [15:0] e;
        tx = 0; rx = 0; cyc = 0; prev_stall = 0;
        hq = '0; hr = '0; ht = '0;
        while (rx < 20 && cyc < 300) begin
            stall = (cyc >= 12 && cyc < 17);
            out_rdy[d] = !stall;
            #1;
            if (stall && out_vld[d]) begin
                chk("stall_in_rdy", 32'(in_rdy[d]), 32'd0);
                if (prev_stall) begin
                    chk("stall_hold_q", 32'(out_q[d]), 32'(hq));
                    chk("stall_hold_r", 32'(out_r[d]), 32'(hr));
                    chk("stall_hold_tag", 32'(out_tag[d]), 32'(ht));
                end
                hq = out_q[d]; hr = out_r[d]; ht = out_tag[d];
            end
            prev_stall = stall && out_vld[d];
            if (out_vld[d] && out_rdy[d]) begin
                e = model(sg_a[rx], n_a[rx], d_a[rx]);
                chk("stream_q", 32'(out_q[d]), 32'(e[15:8]));
                chk("stream_r", 32'(out_r[d]), 32'(e[7:0]));
                chk("stream_tag", 32'(out_tag[d]), 32'(rx % 16));
`ifdef SDIV_DZ_FLAG_EN
                chk("stream_dz", 32'(out_dz[d]), 32'(d_a[rx] == 8'h00));
`endif
                rx++;
            end
            if (tx < 20) begin
                in_sgn[d] = sg_a[tx];
                in_n[d]   = n_a[tx];
                in_d[d]   = d_a[tx];
                in_tag[d] = 4'(tx % 16);
                in_vld[d] = 1'b1;
                if (in_rdy[d]) tx++;
            end else begin
                in_vld[d] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_vld[d]  = 1'b0;
        out_rdy[d] = 1'b1;
        chk("stream_count", 32'(rx), 32'd20);
        chk("stream_no_extra", 32'(out_vld[d]), 32'd0);
    endtask

    initial begin
        int stale, w;
        for (int i = 0; i < 2; i++) begin
            in_vld[i] = 1'b0; in_sgn[i] = 1'b0; in_n[i] = '0;
            in_d[i] = '0; in_tag[i] = '0; out_rdy[i] = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            sg_a[i] = 1'($urandom);
            n_a[i]  = 8'($urandom);
            d_a[i]  = (i % 7 == 3) ? 8'h00 : 8'($urandom);
        end
        sg_a[5] = 1'b1; n_a[5] = 8'h80; d_a[5] = 8'hFF;
        sg_a[9] = 1'b1; n_a[9] = 8'hF9; d_a[9] = 8'h02;

        repeat (2) @(negedge clk);
        chk("rst_out_vld", 32'(out_vld[0]), 32'd0);
        chk("rst_out_q", 32'(out_q[0]), 32'd0);
        chk("rst_out_r", 32'(out_r[0]), 32'd0);
        chk("rst_out_tag", 32'(out_tag[0]), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy[0]), 32'd1);
        chk("rst_out_vld4", 32'(out_vld[1]), 32'd0);
`ifdef SDIV_DZ_FLAG_EN
        chk("rst_out_dz", 32'(out_dz[0]), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        single(0, "u200_7",   1'b0, 8'd200, 8'd7,  4'd3, 8'd28, 8'd4,  1'b0, 9);
        single(0, "sm7_2",    1'b1, 8'hF9,  8'h02, 4'd1, 8'hFD, 8'hFF, 1'b0, 9);
        single(0, "s7_m2",    1'b1, 8'h07,  8'hFE, 4'd2, 8'hFD, 8'h01, 1'b0, 9);
        single(0, "u55_0",    1'b0, 8'd55,  8'h00, 4'd4, 8'hFF, 8'd55, 1'b1, 9);
        single(0, "sm5_0",    1'b1, 8'hFB,  8'h00, 4'd5, 8'hFF, 8'hFB, 1'b1, 9);
        single(0, "ovf",      1'b1, 8'h80,  8'hFF, 4'd6, 8'h80, 8'h00, 1'b0, 9);
        single(1, "u200_7_4", 1'b0, 8'd200, 8'd7,  4'd3, 8'd28, 8'd4,  1'b0, 3);

        stream(0);
        stream(1);

        // Six operations in flight, the oldest parked at the stalled output.
        for (int i = 0; i < 6; i++) begin
            in_sgn[0] = 1'b0; in_n[0] = 8'(100 + i); in_d[0] = 8'd3;
            in_tag[0] = 4'(i); in_vld[0] = 1'b1;
            @(negedge clk);
        end
        in_vld[0] = 1'b0;
        w = 0;
        while (!out_vld[0] && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("pre_rst_out_vld", 32'(out_vld[0]), 32'd1);
        out_rdy[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_vld", 32'(out_vld[0]), 32'd0);
        chk("async_rst_in_rdy", 32'(in_rdy[0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_rdy[0] = 1'b1;
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_vld[0]) stale++;
        end
        chk("no_stale_after_rst", 32'(stale), 32'd0);
        single(0, "u9_3", 1'b0, 8'd9, 8'd3, 4'd7, 8'd3, 8'd0, 1'b0, 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
